uart_ascii_rx: RTL and testbench
================================

# uart_ascii_rx

UART receive path for the distance link. It deserialises 8N1 bytes from `UART_rx` and parses the fixed 10-character ASCII line `DDD.DDDcm\n`, which is the same format our transmit side emits. For each well-formed line it outputs the 6-digit decimal value as a binary integer. It sits between the board RX pin and any consumer of remote measurements, such as the W5500 bridge or a display.

## Interface
- `CLK`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `clk`  in  1: system clock. All logic runs on the rising edge.
- `rst`  in  1: reset. Synchronous, active-high.
- `UART_rx`  in  1: asynchronous serial input. Idles high.
- `rx_byte`  out  8: last received byte. Reset value 0.
- `rx_valid`  out  1: one-cycle strobe marking `rx_byte` as new. Reset value 0.
- `value`  out  20: last parsed line value, range 0..999999. Reset value 0.
- `value_valid`  out  1: one-cycle strobe marking `value` as new. Reset value 0.
- `frame_err`  out  1: one-cycle strobe for a bad stop bit or a format mismatch. Reset value 0.

## Operation
**Byte receiver**
- `BAUD_DIV = CLK/BAUD` using integer division; 434 at the defaults. `HALF = BAUD_DIV/2`, which is 217.
- `UART_rx` passes through a 2-FF synchroniser, giving `rx_s`.
- States: IDLE, START, DATA, STOP.
- IDLE: a falling edge on `rx_s` moves to START and clears the baud counter.
- START: after HALF cycles, sample `rx_s`.
  - If it is 1, treat it as a glitch and return to IDLE with no output.
  - If it is 0, go to DATA.
- DATA: sample 8 bits, LSB first, at successive `BAUD_DIV` intervals. This places each sample mid-bit.
- STOP: sample one more `BAUD_DIV` later.
  - If the sample is 1, load `rx_byte` and pulse `rx_valid`.
  - If the sample is 0, pulse `frame_err` instead of `rx_valid`, and also issue an internal `bad_byte` to the parser.
  - In both cases, wait in IDLE until `rx_s` is high before arming edge detection again.

**Line parser**
- The parser acts on `rx_valid` or `bad_byte` only. It has two states, PARSE and HUNT.
- Position counter `pos` runs 0..9. Expected byte at each position:
  - 0–2: a digit '0'..'9'.
  - 3: '.'
  - 4–6: a digit.
  - 7: 'c'
  - 8: 'm'
  - 9: 0x0A.
- On a digit, the accumulator updates as `acc = (acc<<3)+(acc<<1)+(byte-8'h30)`, held at 20 bits. It cannot overflow because the maximum is 999999, below 2^20.
- PARSE, byte matches:
  - At `pos` < 9: increment `pos`.
  - At `pos`==9: `value<=acc`, pulse `value_valid`, clear `acc` and `pos`.
- PARSE, mismatch or `bad_byte`:
  - Pulse `frame_err` and clear `acc` and `pos`.
  - If the offending byte is 0x0A, stay in PARSE. Otherwise go to HUNT.
- HUNT: discard bytes until 0x0A, then return to PARSE with `pos`=0. No `frame_err` pulses are raised inside HUNT.
- Reset enters PARSE with `pos`=0 and `acc`=0. Reset mid-byte abandons the byte and produces no strobe.

## Timing
- Falling edge on `UART_rx` to `rx_valid`: 2 synchroniser cycles + HALF + 9·`BAUD_DIV` + 1. At the defaults this is 4126 cycles ±1 for edge phase.
- `value_valid` is asserted one cycle after the `rx_valid` of the terminating 0x0A. It is never coincident with `rx_valid`.
- Parser `frame_err` comes one cycle after the bad byte's `rx_valid`. Stop-bit `frame_err` comes in the stop-sample cycle + 1.
- All strobes last exactly one cycle. `rx_byte` and `value` hold until the next update.
- Back-to-back bytes with a single stop bit and no idle gap must be received. The receiver re-arms at the mid-stop sample, which leaves half a bit of margin.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_50MHz` and `BAUD` defaults.
  - A `BAUD_DIV` function.
  - ASCII constants `ASC_0`, `ASC_DOT`, `ASC_C`, `ASC_M`, `ASC_LF`.
  - Enums for the receiver and parser states.
- Sub-module `uart_rx_byte` contains the synchroniser, the receiver FSM and the stop check, and outputs `rx_byte`, `rx_valid` and `bad_byte`.
- The top module `uart_ascii_rx` instantiates `uart_rx_byte` and contains the parser.

## Test plan
- Send "123.456cm\n" at 115200 → ten `rx_valid` pulses with the correct bytes, then `value`=123456 with one `value_valid`, and no `frame_err`.
- Send "000.000cm\n" then "999.999cm\n" back-to-back with no idle gap → `value`=0, then `value`=999999.
- Send "12x.456cm\n" then "000.042cm\n" → one `frame_err` at 'x' with no `value_valid` for the first line, then `value`=42.
- Send a byte with stop bit 0 mid-line, followed by a valid line → `frame_err`, no `rx_valid` for that byte, HUNT state, then the next line parses correctly.
- Drive a low glitch of 100 cycles on `UART_rx` → no `rx_valid` and no `frame_err`, and the next byte is received correctly.
- Assert `rst` during the 5th data bit → all outputs 0 the cycle after reset, and a following full line parses correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, divider helper and state types for the UART receive path
package uart_pkg;

    localparam int CLK_50MHz   = 50_000_000;
    localparam int BAUD_115200 = 115_200;

    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;
    localparam logic [7:0] ASC_DOT = 8'h2E;
    localparam logic [7:0] ASC_C   = 8'h63;
    localparam logic [7:0] ASC_M   = 8'h6D;
    localparam logic [7:0] ASC_LF  = 8'h0A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        P_PARSE,
        P_HUNT
    } parse_state_t;

    function automatic int BAUD_DIV(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: synchroniser, bit-timing FSM and stop-bit check
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK  = CLK_50MHz,
    parameter int BAUD = BAUD_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       bad_byte,
    output logic [7:0] data
);

    localparam int DIV  = BAUD_DIV(CLK, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    rx_state_t     state, state_n;
    logic [1:0]    sync;
    logic          rx_s;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic          start_det, cnt_clr, shift_en, done_ok, done_bad;

    assign rx_s = sync[1];

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        done_ok   = 1'b0;
        done_bad  = 1'b0;
        case (state)
            RX_IDLE: begin
                // A 1->0 transition is required, so a line stuck low after a break never re-triggers.
                if (rx_prev && !rx_s) begin
                    start_det = 1'b1;
                    cnt_clr   = 1'b1;
                    state_n   = RX_START;
                end
            end
            RX_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_clr = 1'b1;
                    state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CW'(DIV - 1)) begin
                    cnt_clr  = 1'b1;
                    state_n  = RX_IDLE;
                    done_ok  = rx_s;
                    done_bad = !rx_s;
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX_IDLE;
            sync     <= 2'b00;
            rx_prev  <= 1'b0;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            data     <= 8'h00;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            bad_byte <= 1'b0;
        end else begin
            state    <= state_n;
            sync     <= {sync[0], UART_rx};
            rx_prev  <= rx_s;
            cnt      <= cnt_clr ? '0 : cnt + 1'b1;
            rx_valid <= done_ok;
            bad_byte <= done_bad;
            if (start_det) bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) data <= {rx_s, data[7:1]};
            if (done_ok) rx_byte <= data;
        end
    end

endmodule

// File: rtl/uart_ascii_rx.sv
// rtl/uart_ascii_rx.sv - UART receiver plus "DDD.DDDcm\n" line parser producing a binary value
module uart_ascii_rx
    import uart_pkg::*;
#(
    parameter int CLK  = CLK_50MHz,
    parameter int BAUD = BAUD_115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        UART_rx,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [19:0] value,
    output logic        value_valid,
    output logic        frame_err
);

    logic         bad_byte;
    logic [7:0]   data;
    parse_state_t pstate, pstate_n;
    logic [3:0]   pos, pos_n;
    logic [19:0]  acc, acc_n, value_n;
    logic         value_valid_n, parse_err, parse_err_n;
    logic         is_digit, match;
    logic [7:0]   digit;

    uart_rx_byte #(.CLK(CLK), .BAUD(BAUD)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .UART_rx  (UART_rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .bad_byte (bad_byte),
        .data     (data)
    );

    // The receiver already flags a bad stop bit, so the parser adds only format errors.
    assign frame_err = bad_byte | parse_err;

    always_comb begin
        is_digit      = (data >= ASC_0) && (data <= ASC_9);
        digit         = data - ASC_0;
        match         = 1'b0;
        pstate_n      = pstate;
        pos_n         = pos;
        acc_n         = acc;
        value_n       = value;
        value_valid_n = 1'b0;
        parse_err_n   = 1'b0;
        case (pos)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6: match = is_digit;
            4'd3:    match = (data == ASC_DOT);
            4'd7:    match = (data == ASC_C);
            4'd8:    match = (data == ASC_M);
            4'd9:    match = (data == ASC_LF);
            default: match = 1'b0;
        endcase
        if (rx_valid || bad_byte) begin
            case (pstate)
                P_PARSE: begin
                    if (rx_valid && match) begin
                        if (pos == 4'd9) begin
                            value_n       = acc;
                            value_valid_n = 1'b1;
                            acc_n         = '0;
                            pos_n         = 4'd0;
                        end else begin
                            pos_n = pos + 4'd1;
                            if (is_digit) acc_n = (acc << 3) + (acc << 1) + {12'd0, digit};
                        end
                    end else begin
                        parse_err_n = rx_valid;
                        acc_n       = '0;
                        pos_n       = 4'd0;
                        if (data != ASC_LF) pstate_n = P_HUNT;
                    end
                end
                P_HUNT: begin
                    if (data == ASC_LF) begin
                        pstate_n = P_PARSE;
                        pos_n    = 4'd0;
                        acc_n    = '0;
                    end
                end
                default: pstate_n = P_PARSE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pstate      <= P_PARSE;
            pos         <= 4'd0;
            acc         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            parse_err   <= 1'b0;
        end else begin
            pstate      <= pstate_n;
            pos         <= pos_n;
            acc         <= acc_n;
            value       <= value_n;
            value_valid <= value_valid_n;
            parse_err   <= parse_err_n;
        end
    end

endmodule

// File: tb/tb_uart_ascii_rx.sv
// tb/tb_uart_ascii_rx.sv - directed bench with a line-level scoreboard for uart_ascii_rx
module tb_uart_ascii_rx;

    localparam int CLK_HZ = 3200;
    localparam int BAUD_R = 100;
    localparam int DIV    = CLK_HZ / BAUD_R;
    localparam int K_R = 0, K_V = 1, K_E = 2;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        UART_rx;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [19:0] value;
    logic        value_valid;
    logic        frame_err;

    int    n_pass = 0;
    int    n_total = 0;
    int    cyc = 0;
    int    t_fall = -1;
    int    last_rx = -10;
    bit    lat_done = 0;
    ev_t   ev_q[$];
    ev_t   cur;
    logic [7:0] line_q[$];
    bit    hunting = 0;
    string tmpl = "ddd.dddcm\n";

    uart_ascii_rx #(.CLK(CLK_HZ), .BAUD(BAUD_R)) dut (
        .clk         (clk),
        .rst         (rst),
        .UART_rx     (UART_rx),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .value       (value),
        .value_valid (value_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_ev(input int kind, input int d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        ev_q.push_back(e);
    endtask

    function automatic bit fits(input int p, input logic [7:0] b);
        logic [7:0] t;
        t = tmpl[p];
        if (t == "d") return (b >= "0") && (b <= "9");
        return b == t;
    endfunction

    // Line-level reference: a line is the bytes since the last resync, judged against the template.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        int v;
        logic [7:0] t;
        if (!stop_ok) begin
            push_ev(K_E, 0);
            if (!hunting) begin
                line_q.delete();
                hunting = (b != 8'h0A);
            end else if (b == 8'h0A) hunting = 0;
            return;
        end
        push_ev(K_R, b);
        if (hunting) begin
            if (b == 8'h0A) hunting = 0;
        end else if (fits(line_q.size(), b)) begin
            line_q.push_back(b);
            if (line_q.size() == 10) begin
                v = 0;
                for (int i = 0; i < 10; i++) begin
                    t = tmpl[i];
                    if (t == "d") v = v * 10 + int'(line_q[i]) - 48;
                end
                push_ev(K_V, v);
                line_q.delete();
            end
        end else begin
            push_ev(K_E, 0);
            line_q.delete();
            hunting = (b != 8'h0A);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        UART_rx = 1'b0;
        if (t_fall < 0) t_fall = cyc;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            UART_rx = b[i];
            wait_cycles(DIV);
        end
        UART_rx = stop_ok;
        wait_cycles(DIV);
        if (!stop_ok) begin
            UART_rx = 1'b1;
            wait_cycles(DIV);
        end
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk(rx_byte == 8'h00, {tag, "_rx_byte"}, rx_byte, 0);
        chk(rx_valid == 1'b0, {tag, "_rx_valid"}, rx_valid, 0);
        chk(value == 20'd0, {tag, "_value"}, value, 0);
        chk(value_valid == 1'b0, {tag, "_value_valid"}, value_valid, 0);
        chk(frame_err == 1'b0, {tag, "_frame_err"}, frame_err, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                if (!lat_done && t_fall >= 0) begin
                    lat_done = 1;
                    chk((cyc - t_fall) >= 306 && (cyc - t_fall) <= 308, "first_byte_latency", cyc - t_fall, 307);
                end
                if (ev_q.size() == 0) chk(0, "unexpected_rx_valid", rx_byte, -1);
                else begin
                    cur = ev_q.pop_front();
                    chk(cur.kind == K_R, "rx_valid_event_kind", cur.kind, K_R);
                    chk(int'(rx_byte) == cur.data, "rx_byte", rx_byte, cur.data);
                end
                last_rx = cyc;
            end
            if (value_valid) begin
                chk(!rx_valid && (cyc - last_rx) == 1, "value_valid_timing", cyc - last_rx, 1);
                if (ev_q.size() == 0) chk(0, "unexpected_value_valid", value, -1);
                else begin
                    cur = ev_q.pop_front();
                    chk(cur.kind == K_V, "value_valid_event_kind", cur.kind, K_V);
                    chk(int'(value) == cur.data, "value", value, cur.data);
                end
            end
            if (frame_err) begin
                if (ev_q.size() == 0) chk(0, "unexpected_frame_err", 1, 0);
                else begin
                    cur = ev_q.pop_front();
                    chk(cur.kind == K_E, "frame_err_event_kind", cur.kind, K_E);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        UART_rx = 1'b1;
        rst = 1'b1;
        wait_cycles(3);
        check_outputs_zero("reset");
        rst = 1'b0;
        wait_cycles(10);

        send_line("123.456cm\n");
        wait_cycles(5);
        chk(value == 20'd123456, "value_lit_123456", value, 123456);

        send_line("000.000cm\n");
        send_line("999.999cm\n");
        wait_cycles(5);
        chk(value == 20'd999999, "value_lit_999999", value, 999999);

        send_line("12x.456cm\n");
        send_line("000.042cm\n");
        wait_cycles(5);
        chk(value == 20'd42, "value_lit_42", value, 42);

        send_line("12");
        send_byte("Z", 1'b0);
        send_line("3.456cm\n");
        send_line("321.000cm\n");
        wait_cycles(5);
        chk(value == 20'd321000, "value_lit_321000", value, 321000);

        UART_rx = 1'b0;
        wait_cycles(6);
        UART_rx = 1'b1;
        wait_cycles(3 * DIV);
        send_line("808.080cm\n");
        wait_cycles(5);
        chk(value == 20'd808080, "value_lit_808080", value, 808080);

        send_line("55");
        q = "Q";
        UART_rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 4; i++) begin
            UART_rx = q[i];
            wait_cycles(DIV);
        end
        UART_rx = q[4];
        wait_cycles(DIV / 2);
        chk(ev_q.size() == 0, "events_drained_before_reset", ev_q.size(), 0);
        rst = 1'b1;
        UART_rx = 1'b1;
        wait_cycles(1);
        check_outputs_zero("midbyte_reset");
        wait_cycles(1);
        rst = 1'b0;
        line_q.delete();
        hunting = 0;
        wait_cycles(2 * DIV);
        send_line("007.500cm\n");
        wait_cycles(5);
        chk(value == 20'd7500, "value_lit_7500", value, 7500);

        wait_cycles(20);
        chk(ev_q.size() == 0, "all_expected_events_seen", ev_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
